// File: rtl/shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// _5BitAdder
//   5-bit ripple-carry adder built from five single-bit full-adder stages.
//   Ports:
//     A, B  in  5  addends (unsigned)
//     cin   in  1  carry into bit 0
//     sum   out 5  A + B + cin, low five bits
//     cout  out 1  carry out of bit 4
// ---------------------------------------------------------------------------
module _5BitAdder (
  input  logic [4:0] A,
  input  logic [4:0] B,
  input  logic       cin,
  output logic [4:0] sum,
  output logic       cout
);

  logic [5:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < 5; i++) begin : g_stage
    assign sum[i]     = A[i] ^ B[i] ^ carry[i];
    assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
  end

  assign cout = carry[5];

endmodule

// ---------------------------------------------------------------------------
// shift_add_multiplier
//   Sequential 5x5 unsigned multiplier. A single _5BitAdder is reused once
//   per clock over five iterations (one per multiplier bit, LSB first).
//   Ports:
//     clk      in  1   rising-edge clock
//     rst      in  1   synchronous, active-high reset
//     start    in  1   request a multiply; only honoured in IDLE
//     A        in  5   multiplicand, captured on the accepted start edge
//     B        in  5   multiplier, captured on the accepted start edge
//     busy     out 1   high while iterating (CALC)
//     done     out 1   single-cycle completion pulse (DONE)
//     product  out 10  registered result, held until next completion/reset
// ---------------------------------------------------------------------------
module shift_add_multiplier (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] A,
  input  logic [4:0] B,
  output logic       busy,
  output logic       done,
  output logic [9:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [4:0] mcand, mcand_nxt;
  logic [4:0] hi, hi_nxt;
  logic [4:0] mplier, mplier_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic [9:0] product_nxt;

  logic [4:0] add_sum;
  logic       add_cout;
  logic [5:0] addend;
  logic [9:0] shifted;

  _5BitAdder u_adder (
    .A    (hi),
    .B    (mcand),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Select hi+mcand when the current multiplier bit is set, otherwise pass hi
  // through. The 6-bit selection sits above mplier; shifting the 11-bit word
  // right by one keeps the adder carry as the new hi[4] and moves the freshly
  // settled product bit into mplier[4] as the spent multiplier bit drops out.
  always_comb begin
    addend  = mplier[0] ? {add_cout, add_sum} : {1'b0, hi};
    shifted = {addend, mplier[4:1]};
  end

  always_comb begin
    state_nxt   = state;
    mcand_nxt   = mcand;
    hi_nxt      = hi;
    mplier_nxt  = mplier;
    cnt_nxt     = cnt;
    product_nxt = product;

    unique case (state)
      IDLE: begin
        if (start) begin
          mcand_nxt  = A;
          mplier_nxt = B;
          hi_nxt     = '0;
          cnt_nxt    = '0;
          state_nxt  = CALC;
        end
      end
      CALC: begin
        hi_nxt     = shifted[9:5];
        mplier_nxt = shifted[4:0];
        cnt_nxt    = cnt + 3'd1;
        if (cnt == 3'd4) begin
          product_nxt = shifted;
          state_nxt   = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= '0;
      hi      <= '0;
      mplier  <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      state   <= state_nxt;
      mcand   <= mcand_nxt;
      hi      <= hi_nxt;
      mplier  <= mplier_nxt;
      cnt     <= cnt_nxt;
      product <= product_nxt;
    end
  end

  // Status outputs depend on the state register only.
  always_comb begin
    busy = (state == CALC);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] A;
  logic [4:0] B;
  logic       busy;
  logic       done;
  logic [9:0] product;

  int total = 0;
  int bad   = 0;

  shift_add_multiplier dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; drives the request immediately so that
  // consecutive calls issue at the 7-cycle interval. Returns at the negedge
  // after the DONE cycle (IDLE again).
  task automatic mul_check(input string tag, input logic [4:0] a,
                           input logic [4:0] b, input int exp);
    int n;
    A = a; B = b; start = 1'b1;
    @(negedge clk);                 // after E0
    start = 1'b0;
    A = ~a; B = ~b;                 // operands must not matter any more
    n = 0;
    while (busy && n < 10) begin
      n++;
      @(negedge clk);
    end
    check({tag, ".busy_cycles"}, n, 5);
    check({tag, ".done"}, int'(done), 1);
    check({tag, ".product"}, int'(product), exp);
    @(negedge clk);                 // after E6
    check({tag, ".done_end"}, int'(done), 0);
  endtask

  initial begin
    int dcnt;
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    check("reset.busy", int'(busy), 0);
    check("reset.done", int'(done), 0);
    check("reset.product", int'(product), 0);
    rst = 1'b0;
    @(negedge clk);

    // Max operands plus hold
    mul_check("max", 5'd31, 5'd31, 961);
    repeat (4) @(negedge clk);
    check("max.hold", int'(product), 961);

    // Zero and carry patterns
    mul_check("zero", 5'd0, 5'd17, 0);
    mul_check("mix", 5'd21, 5'd6, 126);
    mul_check("carry", 5'd16, 5'd31, 496);

    // Start while not idle
    A = 5'd3; B = 5'd5; start = 1'b1;
    @(negedge clk);                 // after E0
    start = 1'b0;
    @(negedge clk);                 // after E1
    A = 5'd7; B = 5'd7; start = 1'b1;
    @(negedge clk);                 // after E2
    start = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 10 && !done; i++) @(negedge clk);
    if (done) dcnt++;
    check("busy_start.product", int'(product), 15);
    start = 1'b1;                   // pulse during DONE
    @(negedge clk);                 // after E6, IDLE
    start = 1'b0;
    if (done) dcnt++;
    check("busy_start.busy_idle", int'(busy), 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("busy_start.done_count", dcnt, 1);
    check("busy_start.product_hold", int'(product), 15);
    mul_check("after_busy", 5'd7, 5'd7, 49);

    // Reset mid-operation
    A = 5'd9; B = 5'd9; start = 1'b1;
    @(negedge clk);                 // after E0
    start = 1'b0;
    @(negedge clk);                 // after E1
    @(negedge clk);                 // after E2
    rst = 1'b1;
    @(negedge clk);                 // after E3
    rst = 1'b0;
    check("midrst.busy", int'(busy), 0);
    check("midrst.done", int'(done), 0);
    check("midrst.product", int'(product), 0);
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    check("midrst.no_activity", dcnt, 0);
    mul_check("after_rst", 5'd2, 5'd3, 6);

    // Reset priority over start
    rst = 1'b1; start = 1'b1; A = 5'd5; B = 5'd5;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rstprio.busy", int'(busy), 0);
    check("rstprio.done", int'(done), 0);
    check("rstprio.product", int'(product), 0);
    @(negedge clk);
    check("rstprio.still_idle", int'(busy), 0);

    // Exhaustive, back-to-back
    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        mul_check($sformatf("ex_%0d_%0d", a, b), 5'(a), 5'(b), a * b);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule
